// File: rtl/time_msg_pkg.sv
// ============================================================================
// time_msg_pkg : constants and types shared by the time-sync formatter/parser
// Rev 1.0
// ============================================================================
`default_nettype none

package time_msg_pkg;

  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int FRAME_LEN = 11;

  // Byte positions within "T:HH:MM:SS\n"
  localparam logic [3:0] IDX_PREFIX = 4'd0;
  localparam logic [3:0] IDX_SEP0   = 4'd1;
  localparam logic [3:0] IDX_H1     = 4'd2;
  localparam logic [3:0] IDX_H0     = 4'd3;
  localparam logic [3:0] IDX_SEP1   = 4'd4;
  localparam logic [3:0] IDX_M1     = 4'd5;
  localparam logic [3:0] IDX_M0     = 4'd6;
  localparam logic [3:0] IDX_SEP2   = 4'd7;
  localparam logic [3:0] IDX_S1     = 4'd8;
  localparam logic [3:0] IDX_S0     = 4'd9;
  localparam logic [3:0] IDX_LF     = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } time_bcd_t;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_formatter_if.sv
// ============================================================================
// time_formatter_if : valid/ready byte stream toward the UART transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

interface time_formatter_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

`default_nettype wire

// File: rtl/bin2bcd2.sv
// ============================================================================
// bin2bcd2 : combinational 6-bit binary to two BCD digits (0..63 -> "00".."63")
// Rev 1.0
// ============================================================================
`default_nettype none

module bin2bcd2 (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  assign tens  = 4'(bin / 6'd10);
  assign units = 4'(bin % 6'd10);

endmodule

`default_nettype wire

// File: rtl/time_formatter.sv
// ============================================================================
// time_formatter : serialises a binary hh:mm:ss as the frame "T:HH:MM:SS\n"
// Rev 1.0
// ============================================================================
`default_nettype none

module time_formatter
  import time_msg_pkg::*;
#(
  parameter logic [7:0] PREFIX   = ASCII_T,
  parameter logic [7:0] SEP      = ASCII_COLON,
  parameter logic [7:0] LINE_END = ASCII_LF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    send,
  input  logic [4:0]              hour,
  input  logic [5:0]              min,
  input  logic [5:0]              sec,
  time_formatter_if.master        stream,
  output logic                    busy,
  output logic                    done
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_idx, w_idx_nxt;
  time_bcd_t  r_bcd, w_bcd_in;
  logic       w_capture;
  logic [7:0] w_data;
  logic       w_valid;

  bin2bcd2 u_hour (.bin({1'b0, hour}), .tens(w_bcd_in.h1), .units(w_bcd_in.h0));
  bin2bcd2 u_min  (.bin(min),          .tens(w_bcd_in.m1), .units(w_bcd_in.m0));
  bin2bcd2 u_sec  (.bin(sec),          .tens(w_bcd_in.s1), .units(w_bcd_in.s0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_capture) r_bcd <= w_bcd_in;
    end
  end

  // Outputs decode from registered state only, so valid never sees ready.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_valid     = 1'b0;
    w_data      = 8'h00;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (send) begin
          w_state_nxt = ST_XMIT;
          w_idx_nxt   = 4'd0;
          w_capture   = 1'b1;
        end
      end
      ST_XMIT: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (stream.data_ready) begin
          if (r_idx == IDX_LF) begin
            w_state_nxt = ST_DONE;
            w_idx_nxt   = 4'd0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_valid) begin
      case (r_idx)
        IDX_PREFIX:                   w_data = PREFIX;
        IDX_SEP0, IDX_SEP1, IDX_SEP2: w_data = SEP;
        IDX_H1:                       w_data = digit_ascii(r_bcd.h1);
        IDX_H0:                       w_data = digit_ascii(r_bcd.h0);
        IDX_M1:                       w_data = digit_ascii(r_bcd.m1);
        IDX_M0:                       w_data = digit_ascii(r_bcd.m0);
        IDX_S1:                       w_data = digit_ascii(r_bcd.s1);
        IDX_S0:                       w_data = digit_ascii(r_bcd.s0);
        IDX_LF:                       w_data = LINE_END;
        default:                      w_data = 8'h00;
      endcase
    end
  end

  assign stream.data       = w_data;
  assign stream.data_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_time_formatter.sv
// ============================================================================
// tb_time_formatter : directed self-checking bench for time_formatter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_time_formatter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       busy;
  logic       done;

  time_formatter_if sif ();

  time_formatter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .send   (send),
    .hour   (hour),
    .min    (min),
    .sec    (sec),
    .stream (sif.master),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receive-side parser model fed from the transfer stream
  logic [7:0] pbuf [0:10];
  int ppos    = 0;
  int pframes = 0;
  int ph = 0, pm = 0, ps = 0;
  bit psynced = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppos    <= 0;
      psynced <= 1'b0;
    end else if (sif.data_valid && sif.data_ready) begin
      if (sif.data == 8'h0A) begin
        ppos <= 0;
        if (ppos == 10 && pbuf[0] == 8'h54 && pbuf[1] == 8'h3A &&
            pbuf[4] == 8'h3A && pbuf[7] == 8'h3A) begin
          psynced <= 1'b1;
          pframes <= pframes + 1;
          ph <= (int'(pbuf[2]) - 48) * 10 + int'(pbuf[3]) - 48;
          pm <= (int'(pbuf[5]) - 48) * 10 + int'(pbuf[6]) - 48;
          ps <= (int'(pbuf[8]) - 48) * 10 + int'(pbuf[9]) - 48;
        end else begin
          psynced <= 1'b0;
        end
      end else if (ppos < 11) begin
        pbuf[ppos] <= sif.data;
        ppos       <= ppos + 1;
      end
    end
  end

  // Results of the most recent capture() run
  logic [7:0] cap_bytes [0:10];
  int cap_n;
  int cap_last;
  bit cap_unstable;
  bit cap_retract;
  bit cap_notbusy;

  task automatic start(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hour = h; min = m; sec = s; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Drives data_ready and records the stream; returns at the cycle after the 11th transfer
  task automatic capture(input bit toggle, input int poke);
    logic [7:0] prev;
    bit stalled;
    prev = 8'h00; stalled = 1'b0;
    cap_n = 0; cap_last = -1;
    cap_unstable = 1'b0; cap_retract = 1'b0; cap_notbusy = 1'b0;
    for (int c = 0; c < 200 && cap_n < 11; c++) begin
      sif.data_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (c == poke) begin
        send = 1'b1; hour = 5'd5;
      end else if (c == poke + 1) begin
        send = 1'b0;
      end
      if (sif.data_valid !== 1'b1) cap_retract = 1'b1;
      if (busy !== 1'b1) cap_notbusy = 1'b1;
      if (stalled && sif.data !== prev) cap_unstable = 1'b1;
      prev = sif.data;
      if (sif.data_valid && sif.data_ready) begin
        cap_bytes[cap_n] = sif.data;
        cap_n++;
        cap_last = c;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      @(negedge clk);
    end
    sif.data_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; send = 1'b0; hour = '0; min = '0; sec = '0;
    sif.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sif.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", sif.data); end
    checks++; if (sif.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sif.data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sif.data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset valid %b busy %b want 0 0", sif.data_valid, busy);
    end
  endtask

  task automatic test_basic();
    string exp = "T:12:34:56\n";
    start(5'd12, 6'd34, 6'd56);
    capture(1'b0, -1);
    checks++; if (cap_n !== 11) begin errors++; $display("FAIL basic_count got %0d want 11", cap_n); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, cap_bytes[i], exp[i]); end
    end
    checks++; if (cap_last !== 10 || cap_retract) begin errors++; $display("FAIL basic_timing last %0d retract %b want 10 0", cap_last, cap_retract); end
    checks++; if (cap_notbusy) begin errors++; $display("FAIL basic_busy got low want high during frame"); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || sif.data_valid !== 1'b0 || sif.data !== 8'h00) begin
      errors++; $display("FAIL basic_done done %b busy %b valid %b data %h want 1 0 0 00", done, busy, sif.data_valid, sif.data);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    string exp = "T:00:00:00\n";
    start(5'd0, 6'd0, 6'd0);
    capture(1'b1, -1);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, cap_bytes[i], exp[i]); end
    end
    checks++; if (cap_last !== 20) begin errors++; $display("FAIL bp_last_transfer got %0d want 20", cap_last); end
    checks++; if (cap_unstable || cap_retract) begin
      errors++; $display("FAIL bp_stable unstable %b retract %b want 0 0", cap_unstable, cap_retract);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_range();
    string exp_a = "T:31:63:63\n";
    string exp_b = "T:23:59:59\n";
    start(5'd31, 6'd63, 6'd63);
    capture(1'b0, -1);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp_a[i]) begin errors++; $display("FAIL range_a_byte%0d got %h want %h", i, cap_bytes[i], exp_a[i]); end
    end
    @(negedge clk);
    start(5'd23, 6'd59, 6'd59);
    capture(1'b0, -1);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL range_b_byte%0d got %h want %h", i, cap_bytes[i], exp_b[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    string exp_a = "T:12:34:56\n";
    string exp_b = "T:05:34:56\n";
    start(5'd12, 6'd34, 6'd56);
    capture(1'b0, 4);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp_a[i]) begin errors++; $display("FAIL b2b_first_byte%0d got %h want %h", i, cap_bytes[i], exp_a[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    send = 1'b1;
    @(negedge clk);
    checks++; if (sif.data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_send_in_done valid %b busy %b want 0 0", sif.data_valid, busy);
    end
    @(negedge clk);
    send = 1'b0;
    capture(1'b0, -1);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_second_byte%0d got %h want %h", i, cap_bytes[i], exp_b[i]); end
    end
    @(negedge clk);
    checks++; if (sif.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_third got %b want 0", sif.data_valid); end
  endtask

  task automatic test_reset_midframe();
    string exp = "T:01:02:03\n";
    int pf;
    start(5'd12, 6'd34, 6'd56);
    sif.data_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (sif.data !== 8'h33) begin errors++; $display("FAIL mid_index5 got %h want 33", sif.data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.data_valid !== 1'b0 || busy !== 1'b0 || sif.data !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset valid %b busy %b data %h done %b want 0 0 00 0", sif.data_valid, busy, sif.data, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pf = pframes;
    start(5'd1, 6'd2, 6'd3);
    capture(1'b0, -1);
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_bytes[i] !== exp[i]) begin errors++; $display("FAIL mid_after_byte%0d got %h want %h", i, cap_bytes[i], exp[i]); end
    end
    checks++; if (pframes !== pf + 1 || ph !== 1 || pm !== 2 || ps !== 3) begin
      errors++; $display("FAIL mid_parser frames %0d time %0d:%0d:%0d want %0d 1:2:3", pframes, ph, pm, ps, pf + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int pf;
    pf = pframes;
    start(5'd12, 6'd34, 6'd56);
    capture(1'b0, -1);
    checks++; if (psynced !== 1'b1 || pframes !== pf + 1) begin
      errors++; $display("FAIL loop_synced synced %b frames %0d want 1 %0d", psynced, pframes, pf + 1);
    end
    checks++; if (ph !== 12 || pm !== 34 || ps !== 56) begin
      errors++; $display("FAIL loop_time got %0d:%0d:%0d want 12:34:56", ph, pm, ps);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_backpressure();
    test_range();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
